// File: rtl/clk_domain_manager_pkg.sv
// rtl/clk_domain_manager_pkg.sv - shared state type, loss-counter constants and width helper
package clk_domain_manager_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } cdm_state_t;

    localparam int LOSS_CNT_W = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

    // Counter only has to reach cycles-1, so clog2(cycles) bits suffice; never narrower than 1.
    function automatic int cycle_cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/ce_channel.sv
// rtl/ce_channel.sv - one divide/phase clock-enable channel with shadow configuration
module ce_channel #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             keep_running,
    input  logic             cfg_load,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic [DIV_W-1:0] phase_cfg,
    output logic             ce
);

    logic [DIV_W-1:0] div_sh;
    logic [DIV_W-1:0] phase_sh;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] ph_eff;
    logic [DIV_W-1:0] cnt;

    always_comb begin
        div_eff = (div_sh <= DIV_W'(1)) ? DIV_W'(1) : div_sh;
        ph_eff  = (phase_sh >= div_eff) ? '0 : phase_sh;
    end

    // keep_running is low whenever the next cycle will not be RUN, so the counter
    // already sits at 0 on the first RUN cycle and every channel starts aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_sh   <= DIV_W'(DEFAULT_DIV);
            phase_sh <= '0;
            cnt      <= '0;
        end else begin
            if (cfg_load) begin
                div_sh   <= div_cfg;
                phase_sh <= phase_cfg;
            end
            if (!keep_running || cfg_load) begin
                cnt <= '0;
            end else if (cnt == div_eff - DIV_W'(1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

    assign ce = run && (cnt == ph_eff);

endmodule

// File: rtl/clk_domain_manager.sv
// rtl/clk_domain_manager.sv - PLL lock supervisor, sequenced reset and phase-programmable clock enables
module clk_domain_manager
    import clk_domain_manager_pkg::*;
#(
    parameter int N_CH               = 2,
    parameter int DIV_W              = 16,
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int DEFAULT_DIV        = 8
) (
    input  logic                    clk_96MHz,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic [N_CH*DIV_W-1:0]   div_cfg,
    input  logic [N_CH*DIV_W-1:0]   phase_cfg,
    input  logic                    cfg_load,
    output logic [N_CH-1:0]         ce,
    output logic                    sys_rst,
    output logic                    ready,
    output logic                    lock_lost,
    output logic [LOSS_CNT_W-1:0]   lock_loss_cnt
);

    localparam int STABLE_W = cycle_cnt_width(LOCK_STABLE_CYCLES);
    localparam int HOLD_W   = cycle_cnt_width(RST_HOLD_CYCLES);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RST_HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   lock_s;
    cdm_state_t             state;
    logic [STABLE_W-1:0]    stable_cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   loss_event;
    logic                   run_now;
    logic                   keep_running;

    assign lock_s       = lock_sync[SYNC_STAGES-1];
    assign loss_event   = !lock_s && (state == HOLD || state == RUN);
    assign run_now      = (state == RUN);
    assign keep_running = run_now && lock_s;

    always_ff @(posedge clk_96MHz) begin
        if (rst) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // A low lock_s wins over every other transition, including HOLD->RUN.
    always_ff @(posedge clk_96MHz) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            stable_cnt <= '0;
            hold_cnt   <= '0;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
        end else if (!lock_s) begin
            state   <= WAIT_LOCK;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    state      <= STABLE;
                    stable_cnt <= '0;
                end
                STABLE: begin
                    if (stable_cnt == STABLE_LAST) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + STABLE_W'(1);
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state   <= RUN;
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= WAIT_LOCK;
                end
            endcase
        end
    end

    always_ff @(posedge clk_96MHz) begin
        if (rst) begin
            lock_lost     <= 1'b0;
            lock_loss_cnt <= '0;
        end else if (loss_event) begin
            lock_lost <= 1'b1;
            if (lock_loss_cnt != LOSS_CNT_MAX) begin
                lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ce_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk          (clk_96MHz),
            .rst          (rst),
            .run          (run_now),
            .keep_running (keep_running),
            .cfg_load     (cfg_load),
            .div_cfg      (div_cfg[i*DIV_W +: DIV_W]),
            .phase_cfg    (phase_cfg[i*DIV_W +: DIV_W]),
            .ce           (ce[i])
        );
    end

endmodule

// File: tb/tb_clk_domain_manager.sv
// tb/tb_clk_domain_manager.sv - scoreboard bench with a timeline-based reference model
module tb_clk_domain_manager;

    localparam int N_CH    = 2;
    localparam int DIV_W   = 16;
    localparam int SYNC    = 2;
    localparam int LS      = 8;
    localparam int RH      = 4;
    localparam int DEF_DIV = 8;
    localparam int MAXC    = 16384;

    logic                  clk_96MHz = 1'b0;
    logic                  rst = 1'b0;
    logic                  pll_locked = 1'b0;
    logic                  cfg_load = 1'b0;
    logic [N_CH*DIV_W-1:0] div_cfg = '0;
    logic [N_CH*DIV_W-1:0] phase_cfg = '0;
    logic [N_CH-1:0]       ce;
    logic                  sys_rst;
    logic                  ready;
    logic                  lock_lost;
    logic [7:0]            lock_loss_cnt;

    clk_domain_manager #(
        .N_CH               (N_CH),
        .DIV_W              (DIV_W),
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (LS),
        .RST_HOLD_CYCLES    (RH),
        .DEFAULT_DIV        (DEF_DIV)
    ) dut (
        .clk_96MHz     (clk_96MHz),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .div_cfg       (div_cfg),
        .phase_cfg     (phase_cfg),
        .cfg_load      (cfg_load),
        .ce            (ce),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .lock_lost     (lock_lost),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk_96MHz = ~clk_96MHz;

    typedef struct {
        bit            known;
        int            cyc;
        bit            sys_rst;
        bit            ready;
        bit [N_CH-1:0] ce;
        bit            lock_lost;
        int            loss_cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;

    // Reference model: timeline of when lock was first seen, loads and resets.
    int cyc = 0;
    bit known = 0;
    int last_rst = -100;
    bit armed = 0;
    int t_first = 0;
    int losses = 0;
    int last_load = -100;
    int m_div[N_CH];
    int m_ph[N_CH];
    bit pll_hist[MAXC];

    function automatic bit lock_s_at(input int c);
        if (c - SYNC <= last_rst || c - SYNC < 0) return 1'b0;
        return pll_hist[c - SYNC];
    endfunction

    task automatic step(input bit r, input bit pll, input bit ld,
                        input int d0, input int p0, input int d1, input int p1);
        exp_t e;
        bit   ls;
        int   run_start;
        int   t_ref;
        int   dd;
        int   pp;
        @(negedge clk_96MHz);
        rst        = r;
        pll_locked = pll;
        cfg_load   = ld;
        div_cfg    = {DIV_W'(d1), DIV_W'(d0)};
        phase_cfg  = {DIV_W'(p1), DIV_W'(p0)};
        pll_hist[cyc] = pll;
        ls = lock_s_at(cyc);
        run_start   = t_first + 1 + LS + RH;
        e.known     = known;
        e.cyc       = cyc;
        e.lock_lost = (losses > 0);
        e.loss_cnt  = (losses > 255) ? 255 : losses;
        e.ready     = armed && (cyc >= run_start);
        e.sys_rst   = !e.ready;
        e.ce        = '0;
        if (e.ready) begin
            t_ref = (last_load + 1 > run_start) ? last_load + 1 : run_start;
            for (int ch = 0; ch < N_CH; ch++) begin
                dd = (m_div[ch] <= 1) ? 1 : m_div[ch];
                pp = (m_ph[ch] >= dd) ? 0 : m_ph[ch];
                e.ce[ch] = (((cyc - t_ref) % dd) == pp);
            end
        end
        sb_q.push_back(e);
        if (r) begin
            known     = 1;
            last_rst  = cyc;
            armed     = 0;
            losses    = 0;
            last_load = -100;
            for (int ch = 0; ch < N_CH; ch++) begin
                m_div[ch] = DEF_DIV;
                m_ph[ch]  = 0;
            end
        end else begin
            if (ld) begin
                m_div[0]  = d0;
                m_ph[0]   = p0;
                m_div[1]  = d1;
                m_ph[1]   = p1;
                last_load = cyc;
            end
            if (armed && !ls) begin
                if (cyc >= t_first + 1 + LS) losses++;
                armed = 0;
            end else if (!armed && ls) begin
                armed   = 1;
                t_first = cyc;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit pll);
        for (int k = 0; k < n; k++) step(1'b0, pll, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_96MHz);
            #1;
            if (sb_q.size() == 0) begin
                if (!done) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty cycle %0d: got 0 entries expected 1", cyc);
                end
            end else begin
                e = sb_q.pop_front();
                if (e.known) begin
                    chk("sys_rst",       e.cyc, 32'(sys_rst),       32'(e.sys_rst));
                    chk("ready",         e.cyc, 32'(ready),         32'(e.ready));
                    chk("ce",            e.cyc, 32'(ce),            32'(e.ce));
                    chk("lock_lost",     e.cyc, 32'(lock_lost),     32'(e.lock_lost));
                    chk("lock_loss_cnt", e.cyc, 32'(lock_loss_cnt), 32'(e.loss_cnt));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        for (int ch = 0; ch < N_CH; ch++) begin
            m_div[ch] = DEF_DIV;
            m_ph[ch]  = 0;
        end
        repeat (3) step(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        idle(30, 1'b1);
        step(1'b0, 1'b1, 1'b1, 3, 1, 0, 5);
        idle(20, 1'b1);

        step(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        idle(6, 1'b1);
        idle(3, 1'b0);
        idle(30, 1'b1);

        repeat (300) begin
            idle(3, 1'b0);
            idle(17, 1'b1);
        end

        step(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        idle(12, 1'b1);
        idle(6, 1'b0);
        idle(25, 1'b1);

        repeat (800) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 14) == 0),
                 int'($urandom_range(0, 9)), int'($urandom_range(0, 11)),
                 int'($urandom_range(0, 9)), int'($urandom_range(0, 11)));
        end
        done = 1;
        @(negedge clk_96MHz);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
